// File: rtl/lcd_controller.sv
// HD44780 4-bit sequencer: autonomous power-on init and config, then byte writes over an oReady/iWrite handshake.
// First nibble is driven on the accept edge; oReady stays low until the byte has fully settled, and iWrite is ignored while low.
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_4MS     = 205000,
  parameter int T_100US   = 5000,
  parameter int T_40US    = 2000,
  parameter int T_1US     = 50,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oInitDone,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_DATA
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_4MS), max2(T_100US, T_40US)),
                              max2(max2(T_1US, T_CLEAR), T_SETUP + T_EPULSE + 1));
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWR_LAST    = cnt_t'(T_POWERUP - 1);
  localparam cnt_t W4MS_LAST   = cnt_t'(T_4MS - 1);
  localparam cnt_t W100US_LAST = cnt_t'(T_100US - 1);
  localparam cnt_t W40US_LAST  = cnt_t'(T_40US - 1);
  localparam cnt_t GAP_LAST    = cnt_t'(T_1US - 1);
  localparam cnt_t CLEAR_LAST  = cnt_t'(T_CLEAR - 1);
  localparam cnt_t E_ON        = cnt_t'(T_SETUP - 1);
  localparam cnt_t E_OFF       = cnt_t'(T_SETUP + T_EPULSE - 1);
  localparam cnt_t NIB_LAST    = cnt_t'(T_SETUP + T_EPULSE);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_IDLE,
    S_WR_HI,
    S_GAP,
    S_WR_LO,
    S_SETTLE
  } state_t;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  logic       cfg_q, cfg_d;
  logic [7:0] byte_q, byte_d;
  logic       rs_q, rs_d;
  logic [3:0] nib_q, nib_d;
  logic       e_q, e_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  logic       pulse_on;
  logic       nib_end;
  cnt_t       init_wait_last;
  cnt_t       settle_last;
  logic [7:0] next_cfg;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + cnt_t'(1);
    step_d   = step_q;
    cfg_d    = cfg_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    nib_d    = nib_q;
    e_d      = 1'b0;
    next_cfg = cfg_byte(step_q + 2'd1);

    // Counter runs from 0 on the edge that first drives the nibble.
    pulse_on = (cnt_q >= E_ON) && (cnt_q < E_OFF);
    nib_end  = (cnt_q == NIB_LAST);

    case (step_q)
      2'd0:    init_wait_last = W4MS_LAST;
      2'd1:    init_wait_last = W100US_LAST;
      default: init_wait_last = W40US_LAST;
    endcase

    // Clear and return-home commands need the long settle.
    if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
      settle_last = CLEAR_LAST;
    else
      settle_last = W40US_LAST;

    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_INIT_NIB;
          cnt_d   = '0;
          step_d  = 2'd0;
          nib_d   = 4'h3;
          rs_d    = 1'b0;
        end
      end
      S_INIT_NIB: begin
        e_d = pulse_on;
        if (nib_end) begin
          state_d = S_INIT_WAIT;
          cnt_d   = '0;
        end
      end
      S_INIT_WAIT: begin
        if (cnt_q == init_wait_last) begin
          cnt_d = '0;
          if (step_q == 2'd3) begin
            state_d = S_WR_HI;
            cfg_d   = 1'b1;
            step_d  = 2'd0;
            byte_d  = cfg_byte(2'd0);
            nib_d   = cfg_byte(2'd0) >> 4;
            rs_d    = 1'b0;
          end else begin
            state_d = S_INIT_NIB;
            step_d  = step_q + 2'd1;
            nib_d   = (step_q == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (iWrite) begin
          state_d = S_WR_HI;
          cfg_d   = 1'b0;
          byte_d  = iData;
          rs_d    = iRS;
          nib_d   = iData[7:4];
        end
      end
      S_WR_HI: begin
        e_d = pulse_on;
        if (nib_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_WR_LO;
          cnt_d   = '0;
          nib_d   = byte_q[3:0];
        end
      end
      S_WR_LO: begin
        e_d = pulse_on;
        if (nib_end) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == settle_last) begin
          cnt_d = '0;
          if (cfg_q && step_q != 2'd3) begin
            state_d = S_WR_HI;
            step_d  = step_q + 2'd1;
            byte_d  = next_cfg;
            nib_d   = next_cfg[7:4];
          end else begin
            state_d = S_IDLE;
            cfg_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    done_d  = done_q | ready_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_PWR_WAIT;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      cfg_q   <= 1'b0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      cfg_q   <= cfg_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign oReady    = ready_q;
  assign oInitDone = done_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign SF_DATA   = nib_q;

endmodule
